// File: rtl/dsp_divider.sv
// Radix-2 restoring divider recovering Q and R from N = Q*A + R, one quotient bit per clock.
// Optional DSP_DIV_EARLY_EXIT_EN: operands with n_in < a_in finish after a single cycle.
module dsp_divider #(
    parameter int NW = 48,
    parameter int DW = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [NW-1:0] n_in,
    input  logic [DW-1:0] a_in,
    output logic          busy,
    output logic          out_valid,
    output logic [NW-1:0] q_out,
    output logic [DW-1:0] r_out,
    output logic          div_by_zero
);
    // state | meaning
    // IDLE  | waiting for start, operands captured on the accepting edge
    // CALC  | one restoring iteration per edge, counter runs down to 1
    // DONE  | out_valid pulse for one cycle, then back to IDLE
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int CW = $clog2(NW + 1);

    state_t        state_q, state_d;
    logic [NW-1:0] dvd_q, dvd_d;
    logic [DW-1:0] dvs_q, dvs_d;
    logic [DW-1:0] nlo_q, nlo_d;
    logic [DW:0]   rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          early_q, early_d;
    logic [NW-1:0] q_out_q, q_out_d;
    logic [DW-1:0] r_out_q, r_out_d;
    logic          dbz_q, dbz_d;

    logic [DW:0]   rem_sh, rem_nxt;
    logic [NW-1:0] dvd_nxt;
    logic          ge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (cnt_q == CW'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == CALC);
        out_valid = (state_q == DONE);
    end

    // rem_q[DW] is always 0 after a restoring step; folding it into ge keeps the compare exact
    always_comb begin
        rem_sh  = {rem_q[DW-1:0], dvd_q[NW-1]};
        ge      = rem_q[DW] | (rem_sh >= {1'b0, dvs_q});
        rem_nxt = ge ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
        dvd_nxt = {dvd_q[NW-2:0], ge};
    end

    always_comb begin
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        nlo_d   = nlo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        early_d = early_q;
        q_out_d = q_out_q;
        r_out_d = r_out_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = n_in;
                    dvs_d   = a_in;
                    nlo_d   = n_in[DW-1:0];
                    rem_d   = '0;
                    cnt_d   = CW'(NW);
                    early_d = 1'b0;
`ifdef DSP_DIV_EARLY_EXIT_EN
                    if ((a_in != '0) && (n_in < {{(NW-DW){1'b0}}, a_in})) begin
                        cnt_d   = CW'(1);
                        early_d = 1'b1;
                    end
`endif
                end
            end
            CALC: begin
                dvd_d = dvd_nxt;
                rem_d = rem_nxt;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    if (dvs_q == '0) begin
                        q_out_d = '1;
                        r_out_d = nlo_q;
                        dbz_d   = 1'b1;
                    end else if (early_q) begin
                        q_out_d = '0;
                        r_out_d = nlo_q;
                        dbz_d   = 1'b0;
                    end else begin
                        q_out_d = dvd_nxt;
                        r_out_d = rem_nxt[DW-1:0];
                        dbz_d   = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_q   <= '0;
            dvs_q   <= '0;
            nlo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            early_q <= 1'b0;
            q_out_q <= '0;
            r_out_q <= '0;
            dbz_q   <= 1'b0;
        end else begin
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            nlo_q   <= nlo_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            early_q <= early_d;
            q_out_q <= q_out_d;
            r_out_q <= r_out_d;
            dbz_q   <= dbz_d;
        end
    end

    assign q_out       = q_out_q;
    assign r_out       = r_out_q;
    assign div_by_zero = dbz_q;

endmodule
